// File: rtl/mcpu_core_intctl_pkg.sv
// Shared definitions for the core interrupt controller: FSM state encoding,
// register-port addresses and the status word layout.
package mcpu_core_intctl_pkg;

  localparam int unsigned NSRC_MAX = 16;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned CFG_DW   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_INSVC = 2'd2
  } state_e;

  localparam logic [1:0] CFG_MASK   = 2'd0;
  localparam logic [1:0] CFG_EDGE   = 2'd1;
  localparam logic [1:0] CFG_PEND   = 2'd2;
  localparam logic [1:0] CFG_STATUS = 2'd3;

  // Read-only status word: state in [5:4], latched interrupt type in [3:0]
  typedef struct packed {
    logic [25:0]      rsvd;
    state_e           state;
    logic [IDX_W-1:0] itype;
  } status_t;

  function automatic status_t make_status(state_e st, logic [IDX_W-1:0] t);
    status_t s;
    s.rsvd  = '0;
    s.state = st;
    s.itype = t;
    return s;
  endfunction

endpackage

// File: rtl/mcpu_core_intctl_arb.sv
// Picks one eligible interrupt source. MCPU_INTCTL_RR_EN selects round-robin
// search from ptr_i; otherwise fixed priority with the lowest index winning.
module mcpu_core_intctl_arb
  import mcpu_core_intctl_pkg::*;
#(
  parameter int unsigned NSRC = 8
) (
  input  logic [NSRC-1:0]  eligible_i,
`ifdef MCPU_INTCTL_RR_EN
  input  logic [IDX_W-1:0] ptr_i,
`endif
  output logic [NSRC-1:0]  grant_c_o,
  output logic [IDX_W-1:0] idx_c_o,
  output logic             any_c_o
);

  always_comb begin
    logic [NSRC-1:0] shifted;
    int unsigned     j;
    grant_c_o = '0;
    idx_c_o   = '0;
    any_c_o   = 1'b0;
    shifted   = '0;
    j         = 0;
    for (int unsigned k = 0; k < NSRC; k++) begin
`ifdef MCPU_INTCTL_RR_EN
      j = (32'(ptr_i) + k) % NSRC;
`else
      j = k;
`endif
      shifted = eligible_i >> j;
      if (!any_c_o && shifted[0]) begin
        any_c_o   = 1'b1;
        grant_c_o = NSRC'(1) << j;
        idx_c_o   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mcpu_core_intctl.sv
// Core interrupt controller: latches/masks NSRC lines, arbitrates one request
// and holds off until ERET. MCPU_INTCTL_RR_EN enables round-robin arbitration.
module mcpu_core_intctl
  import mcpu_core_intctl_pkg::*;
#(
  parameter int unsigned NSRC = 8
) (
  input  logic              clkrst_core_clk,
  input  logic              clkrst_core_rst,
  input  logic [NSRC-1:0]   irq,
  input  logic              interrupts_enabled,
  input  logic              int_take,
  input  logic              int_eret,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [CFG_DW-1:0] cfg_wdata,
  output logic [CFG_DW-1:0] cfg_rdata,
  output logic              int_req,
  output logic [IDX_W-1:0]  int_type
);

  state_e           state_q, state_d;
  logic [NSRC-1:0]  mask_q, mask_d;
  logic [NSRC-1:0]  edge_q, edge_d;
  logic [NSRC-1:0]  pend_q, pend_d;
  logic [NSRC-1:0]  prev_q;
  logic [NSRC-1:0]  win_q, win_d;
  logic [IDX_W-1:0] type_q, type_d;
  logic             req_q, req_d;
`ifdef MCPU_INTCTL_RR_EN
  logic [IDX_W-1:0] rr_q, rr_d;
`endif

  logic [NSRC-1:0]  cfg_bits;
  logic [NSRC-1:0]  eligible;
  logic [NSRC-1:0]  take_hit;
  logic [NSRC-1:0]  pend_clr;
  logic [NSRC-1:0]  arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic             wr_mask, wr_edge, wr_pend;
  logic             unused_wdata;

  assign cfg_bits     = cfg_wdata[NSRC-1:0];
  assign unused_wdata = ^cfg_wdata[CFG_DW-1:NSRC];
  assign wr_mask      = cfg_we && (cfg_addr == CFG_MASK);
  assign wr_edge      = cfg_we && (cfg_addr == CFG_EDGE);
  assign wr_pend      = cfg_we && (cfg_addr == CFG_PEND);
  assign eligible     = pend_q & mask_q;

  mcpu_core_intctl_arb #(.NSRC(NSRC)) u_arb (
    .eligible_i (eligible),
`ifdef MCPU_INTCTL_RR_EN
    .ptr_i      (rr_q),
`endif
    .grant_c_o  (arb_grant),
    .idx_c_o    (arb_idx),
    .any_c_o    (arb_any)
  );

  // Edge sources: set beats clear; level sources simply follow the registered line
  always_comb begin
    take_hit = (state_q == ST_REQ && int_take) ? win_q : '0;
    pend_clr = (wr_pend ? cfg_bits : '0) | take_hit;
    pend_d   = (edge_q & ((irq & ~prev_q) | (pend_q & ~pend_clr)))
             | (~edge_q & irq);
    mask_d   = wr_mask ? cfg_bits : mask_q;
    edge_d   = wr_edge ? cfg_bits : edge_q;
  end

  // Request FSM: next state, latched winner and registered request
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    win_d   = win_q;
    req_d   = 1'b0;
`ifdef MCPU_INTCTL_RR_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (interrupts_enabled && arb_any) begin
          state_d = ST_REQ;
          type_d  = arb_idx;
          win_d   = arb_grant;
        end
      end
      ST_REQ: begin
        if (int_take) begin
          state_d = ST_INSVC;
`ifdef MCPU_INTCTL_RR_EN
          rr_d    = IDX_W'((32'(type_q) + 32'd1) % 32'(NSRC));
`endif
        end else if (!interrupts_enabled || ((eligible & win_q) == '0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_INSVC: begin
        if (int_eret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    req_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      edge_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      win_q   <= '0;
      type_q  <= '0;
      req_q   <= 1'b0;
`ifdef MCPU_INTCTL_RR_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      pend_q  <= pend_d;
      prev_q  <= irq;
      win_q   <= win_d;
      type_q  <= type_d;
      req_q   <= req_d;
`ifdef MCPU_INTCTL_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      CFG_MASK:   cfg_rdata = CFG_DW'(mask_q);
      CFG_EDGE:   cfg_rdata = CFG_DW'(edge_q);
      CFG_PEND:   cfg_rdata = CFG_DW'(pend_q);
      CFG_STATUS: cfg_rdata = make_status(state_q, type_q);
      default:    cfg_rdata = '0;
    endcase
  end

  assign int_req  = req_q;
  assign int_type = type_q;

endmodule

// File: tb/tb_mcpu_core_intctl.sv
// Scoreboard bench for mcpu_core_intctl: a cycle-level behavioural model
// queues expected state each clock; a monitor compares on the falling edge.
module tb_mcpu_core_intctl;

  localparam int NSRC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic        en, take, eret, we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        req;
  logic [3:0]  typ;

  always #5 clk = ~clk;

  mcpu_core_intctl #(.NSRC(NSRC)) dut (
    .clkrst_core_clk    (clk),
    .clkrst_core_rst    (rst),
    .irq                (irq),
    .interrupts_enabled (en),
    .int_take           (take),
    .int_eret           (eret),
    .cfg_we             (we),
    .cfg_addr           (addr),
    .cfg_wdata          (wdata),
    .cfg_rdata          (rdata),
    .int_req            (req),
    .int_type           (typ)
  );

  // Model state: 0 idle, 1 requesting, 2 in service
  bit [7:0] m_mask, m_edge, m_pend, m_prev;
  int       m_state, m_typ, m_rr;

  typedef struct {
    bit [7:0] mask;
    bit [7:0] edg;
    bit [7:0] pend;
    int       st;
    int       typ;
  } snap_t;
  snap_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit [7:0] e);
    for (int k = 0; k < NSRC; k++) begin
      int j;
`ifdef MCPU_INTCTL_RR_EN
      j = (m_rr + k) % NSRC;
`else
      j = k;
`endif
      if (e[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_step();
    bit [7:0] elig;
    bit [7:0] np;
    if (rst) begin
      m_mask = 0; m_edge = 0; m_pend = 0; m_prev = 0;
      m_state = 0; m_typ = 0; m_rr = 0;
      return;
    end
    elig = m_pend & m_mask;
    for (int i = 0; i < NSRC; i++) begin
      if (m_edge[i]) begin
        if (irq[i] && !m_prev[i]) np[i] = 1'b1;
        else if ((we && addr == 2'd2 && wdata[i]) || (m_state == 1 && take && m_typ == i)) np[i] = 1'b0;
        else np[i] = m_pend[i];
      end else begin
        np[i] = irq[i];
      end
    end
    case (m_state)
      0: if (en && elig != 0) begin m_state = 1; m_typ = pick(elig); end
      1: begin
        if (take) begin
          m_state = 2;
          m_rr = (m_typ + 1) % NSRC;
        end else if (!en || !elig[m_typ]) begin
          m_state = 0;
        end
      end
      default: if (eret) m_state = 0;
    endcase
    if (we && addr == 2'd0) m_mask = wdata[7:0];
    if (we && addr == 2'd1) m_edge = wdata[7:0];
    m_pend = np;
    m_prev = irq;
  endtask

  task automatic tick();
    snap_t s;
    @(posedge clk);
    model_step();
    s.mask = m_mask; s.edg = m_edge; s.pend = m_pend; s.st = m_state; s.typ = m_typ;
    exp_q.push_back(s);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input snap_t s, input logic [1:0] a);
    case (a)
      2'd0:    return {24'd0, s.mask};
      2'd1:    return {24'd0, s.edg};
      2'd2:    return {24'd0, s.pend};
      default: return {26'd0, 2'(s.st), 4'(s.typ)};
    endcase
  endfunction

  // Monitor: one expected record per clock, checked mid-cycle
  initial begin
    snap_t s;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        chk("int_req", {31'd0, req}, (s.st == 1) ? 32'd1 : 32'd0);
        chk("int_type", {28'd0, typ}, 32'(s.typ));
        chk("cfg_rdata", rdata, exp_rd(s, addr));
      end
    end
  end

  initial begin
    int r;
    rst = 1'b1; irq = '0; en = 1'b0; take = 1'b0; eret = 1'b0;
    we = 1'b0; addr = 2'd0; wdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_req", {31'd0, req}, 32'd0);
    chk("reset_type", {28'd0, typ}, 32'd0);
    tick();

    // Edge source 0: request two cycles after the pulse, take clears pending
    wr(2'd0, 32'h01); wr(2'd1, 32'h01);
    en = 1'b1; irq = 8'h01; tick();
    irq = 8'h00; tick();
    chk("edge_req", {31'd0, req}, 32'd1);
    chk("edge_type", {28'd0, typ}, 32'd0);
    take = 1'b1; tick(); take = 1'b0;
    chk("take_req", {31'd0, req}, 32'd0);
    addr = 2'd2; #1;
    chk("take_pend0", {31'd0, rdata[0]}, 32'd0);
    eret = 1'b1; tick(); eret = 1'b0;

    // Level source 3 gated by global enable
    wr(2'd0, 32'h08); wr(2'd1, 32'h00);
    en = 1'b0; irq = 8'h08; tick(); tick(); tick();
    chk("disabled_req", {31'd0, req}, 32'd0);
    en = 1'b1; tick();
    chk("enable_req", {31'd0, req}, 32'd1);
    chk("enable_type", {28'd0, typ}, 32'd3);

    // New edge in service waits for ERET; request at eret+2
    take = 1'b1; tick(); take = 1'b0;
    irq = 8'h00;
    wr(2'd0, 32'h02); wr(2'd1, 32'h02);
    irq = 8'h02; tick(); irq = 8'h00; tick(); tick(); tick();
    chk("insvc_req", {31'd0, req}, 32'd0);
    eret = 1'b1; tick(); eret = 1'b0;
    chk("eret1_req", {31'd0, req}, 32'd0);
    tick();
    chk("eret2_req", {31'd0, req}, 32'd1);
    chk("eret2_type", {28'd0, typ}, 32'd1);

    // Set beats write-1-clear in the same cycle
    wr(2'd1, 32'h06);
    irq = 8'h04; we = 1'b1; addr = 2'd2; wdata = 32'h04; tick(); we = 1'b0;
    addr = 2'd2; #1;
    chk("set_wins_pend2", {31'd0, rdata[2]}, 32'd1);

    // Two level sources, repeated take/ERET
    irq = 8'h00; rst = 1'b1; tick(); rst = 1'b0;
    wr(2'd0, 32'h03);
    en = 1'b1; irq = 8'h03; tick(); tick();
    for (int k = 0; k < 4; k++) begin
`ifdef MCPU_INTCTL_RR_EN
      chk("arb_type", {28'd0, typ}, 32'(k % 2));
`else
      chk("arb_type", {28'd0, typ}, 32'd0);
`endif
      chk("arb_req", {31'd0, req}, 32'd1);
      take = 1'b1; tick(); take = 1'b0;
      eret = 1'b1; tick(); eret = 1'b0;
      tick();
    end

    // Reset while requesting
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_req", {31'd0, req}, 32'd0);
    addr = 2'd0; #1;
    chk("rst_mid_mask", rdata, 32'd0);
    addr = 2'd2; #1;
    chk("rst_mid_pend", rdata, 32'd0);
    irq = 8'h00;

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom % 400) == 0;
      irq   = irq ^ 8'($urandom & $urandom & $urandom);
      en    = ($urandom % 8) != 0;
      r     = int'($urandom % 16);
      take  = (m_state == 1) ? (r < 5) : (r == 0);
      r     = int'($urandom % 16);
      eret  = (m_state == 2) ? (r < 4) : (r == 0);
      we    = ($urandom % 6) == 0;
      addr  = 2'($urandom);
      wdata = $urandom;
      tick();
    end
    rst = 1'b0; we = 1'b0; take = 1'b0; eret = 1'b0;
    tick();
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
